// File: rtl/balance_pkg.sv
`default_nettype none
// ============================================================================
// Module      : balance_pkg
// Description : Shared constants and saturation helpers for the balance-loop
//               PID controller and its soft-start counter.
// Revision    : 1.0  initial release
// ============================================================================
package balance_pkg;

  // Default proportional gain (unsigned)
  localparam logic [4:0] P_COEFF_DEF = 5'h09;

  // Datapath widths
  localparam int ERR_W = 10;  // saturated pitch error
  localparam int INT_W = 18;  // integrator
  localparam int OUT_W = 12;  // PID result
  localparam int SS_W  = 27;  // soft-start counter

  // Saturation limits
  localparam logic signed [15:0] ERR_MAX = 16'sd511;
  localparam logic signed [15:0] ERR_MIN = -16'sd512;
  localparam logic signed [15:0] OUT_MAX = 16'sd2047;
  localparam logic signed [15:0] OUT_MIN = -16'sd2048;

  // Clamp a 16-bit signed pitch into the 10-bit error range
  function automatic logic signed [ERR_W-1:0] sat_err(input logic signed [15:0] v);
    logic signed [ERR_W-1:0] r;
    if (v > ERR_MAX)      r = 10'h1FF;
    else if (v < ERR_MIN) r = 10'h200;
    else                  r = v[ERR_W-1:0];
    return r;
  endfunction

  // Clamp the 16-bit PID sum into the 12-bit output range
  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [15:0] s);
    logic signed [OUT_W-1:0] r;
    if (s > OUT_MAX)      r = 12'h7FF;
    else if (s < OUT_MIN) r = 12'h800;
    else                  r = s[OUT_W-1:0];
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pid_soft_start.sv
`default_nettype none
// ============================================================================
// Module      : pid_soft_start
// Description : Soft-start ramp counter. Clears while power is off, counts up
//               by 1 (or 256 when fast_sim) while power is on, and sticks at
//               all-ones instead of wrapping. ss_tmr is the top 8 bits.
// Revision    : 1.0  initial release
// Ports       : clk       in   system clock
//               rst_n     in   synchronous active-low reset
//               i_pwr_up  in   level, platform enabled
//               o_ss_tmr  out  8-bit soft-start scale
// ============================================================================
module pid_soft_start
  import balance_pkg::*;
#(
  parameter bit fast_sim = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_pwr_up,
  output logic [7:0] o_ss_tmr
);

  localparam logic [SS_W:0] c_step = fast_sim ? (SS_W+1)'(256) : (SS_W+1)'(1);

  logic [SS_W-1:0] r_cnt;
  logic [SS_W:0]   w_cnt_inc;

  // One extra bit catches the carry so the counter can pin at all-ones
  assign w_cnt_inc = {1'b0, r_cnt} + c_step;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_pwr_up) begin
      r_cnt <= '0;
    end else if (w_cnt_inc[SS_W]) begin
      r_cnt <= '1;
    end else begin
      r_cnt <= w_cnt_inc[SS_W-1:0];
    end
  end

  assign o_ss_tmr = r_cnt[SS_W-1 -: 8];

endmodule
`default_nettype wire

// File: rtl/balance_pid.sv
`default_nettype none
// ============================================================================
// Module      : balance_pid
// Description : Two-stage balance-loop PID controller with non-wrapping
//               integrator and optional soft-start ramp.
//               Stage 1 (vld edge): saturate pitch, register error and
//               D term, update integrator.
//               Stage 2 (next edge): sum P+I+D, saturate, strobe pid_vld.
// Revision    : 1.0  initial release
// Config      : BALANCE_PID_SOFT_START_EN - when defined, builds the
//               soft-start counter; otherwise ss_tmr is tied to 8'hFF.
// Ports       : clk        in   system clock
//               rst_n      in   synchronous active-low reset
//               vld        in   one-cycle strobe for ptch / ptch_rt
//               ptch       in   16-bit signed fused pitch
//               ptch_rt    in   16-bit signed pitch rate
//               pwr_up     in   level, platform enabled
//               rider_off  in   level, clears the integrator
//               PID_cntrl  out  12-bit signed PID result (registered)
//               pid_vld    out  one-cycle strobe, PID_cntrl updated
//               ss_tmr     out  8-bit soft-start scale
// ============================================================================
module balance_pid
  import balance_pkg::*;
#(
  parameter bit         fast_sim = 1'b1,
  parameter logic [4:0] P_COEFF  = P_COEFF_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vld,
  input  logic [15:0] ptch,
  input  logic [15:0] ptch_rt,
  input  logic        pwr_up,
  input  logic        rider_off,
  output logic [11:0] PID_cntrl,
  output logic        pid_vld,
  output logic [7:0]  ss_tmr
);

  // Stage-1 registers
  logic                    r_s1_vld;
  logic signed [ERR_W-1:0] r_err;
  logic signed [15:0]      r_d_term;
  logic signed [INT_W-1:0] r_int;

  // Stage-2 registers
  logic                    r_pid_vld;
  logic signed [OUT_W-1:0] r_pid_cntrl;

  // Stage-1 combinational
  logic signed [ERR_W-1:0] w_err_sat;
  logic signed [INT_W-1:0] w_err_ext;
  logic signed [INT_W-1:0] w_int_sum;
  logic                    w_int_ovf;
  logic signed [15:0]      w_rt_shr;
  logic signed [15:0]      w_d_term;

  // Stage-2 combinational
  logic signed [15:0]      w_err16;
  logic signed [15:0]      w_coef16;
  logic signed [15:0]      w_p_term;
  logic signed [15:0]      w_i_term;
  logic signed [15:0]      w_sum;
  logic signed [OUT_W-1:0] w_pid_sat;

  assign w_err_sat = sat_err(ptch);
  assign w_err_ext = {{(INT_W-ERR_W){w_err_sat[ERR_W-1]}}, w_err_sat};
  assign w_int_sum = r_int + w_err_ext;

  // Same-sign addends producing an opposite-sign sum means wrap; hold instead
  assign w_int_ovf = (r_int[INT_W-1] == w_err_ext[INT_W-1]) &&
                     (w_int_sum[INT_W-1] != r_int[INT_W-1]);

  // Arithmetic shift floors; negating -512 yields +512, still fits in 16 bits
  assign w_rt_shr = $signed(ptch_rt) >>> 6;
  assign w_d_term = -w_rt_shr;

  // Gain is unsigned, so zero-extend it before the signed multiply
  assign w_err16  = {{(16-ERR_W){r_err[ERR_W-1]}}, r_err};
  assign w_coef16 = {11'd0, P_COEFF};
  assign w_p_term = w_err16 * w_coef16;

  // Integrator already holds the stage-1 update when stage 2 reads it
  assign w_i_term = {{(16-(INT_W-6)){r_int[INT_W-1]}}, r_int[INT_W-1:6]};

  assign w_sum     = w_p_term + w_i_term + r_d_term;
  assign w_pid_sat = sat_out(w_sum);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_vld    <= 1'b0;
      r_err       <= '0;
      r_d_term    <= '0;
      r_int       <= '0;
      r_pid_vld   <= 1'b0;
      r_pid_cntrl <= '0;
    end else begin
      r_s1_vld <= vld;
      if (vld) begin
        r_err    <= w_err_sat;
        r_d_term <= w_d_term;
      end

      // rider_off wins over accumulation
      if (rider_off) begin
        r_int <= '0;
      end else if (vld && !w_int_ovf) begin
        r_int <= w_int_sum;
      end

      r_pid_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_pid_cntrl <= w_pid_sat;
      end
    end
  end

  assign PID_cntrl = r_pid_cntrl;
  assign pid_vld   = r_pid_vld;

`ifdef BALANCE_PID_SOFT_START_EN
  pid_soft_start #(
    .fast_sim (fast_sim)
  ) u_soft_start (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_pwr_up (pwr_up),
    .o_ss_tmr (ss_tmr)
  );
`else
  // No ramp: full drive always; pwr_up and fast_sim have no effect here
  logic w_unused_pwr_up;
  localparam bit c_unused_fast_sim = fast_sim;
  assign w_unused_pwr_up = pwr_up;
  assign ss_tmr          = 8'hFF;
`endif

endmodule
`default_nettype wire
